ghost_nav_ctrl: RTL and testbench

//  Parametrised ghost motion controller: owns one ghost's position and heading, steps it one

---
 rtl/ghost_nav_if.sv | 27 ++
 rtl/ghost_nav_ctrl.sv | 156 +++++++++++++++
 tb/tb_ghost_nav_ctrl.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/ghost_nav_if.sv
// ghost_nav_if: control and position bundle between a ghost motion controller and its environment.
//   master: drives enable/respawn/mode/target/blocked, observes x/y/direction/step/stuck
//   slave : the controller side
interface ghost_nav_if #(
   parameter int X_W = 10,
   parameter int Y_W = 9
) ();
   logic           enable;
   logic           respawn;
   logic           mode;
   logic [X_W-1:0] target_x;
   logic [Y_W-1:0] target_y;
   logic           blocked;
   logic [X_W-1:0] x;
   logic [Y_W-1:0] y;
   logic [1:0]     direction;
   logic           step;
   logic           stuck;
   modport master (
      output enable, respawn, mode, target_x, target_y, blocked,
      input  x, y, direction, step, stuck
   );
   modport slave (
      input  enable, respawn, mode, target_x, target_y, blocked,
      output x, y, direction, step, stuck
   );
endinterface

// File: rtl/ghost_nav_ctrl.sv
// ghost_nav_ctrl: one ghost's position/heading, stepping on a tick and re-steering when blocked.
//   clk_i  : system clock
//   rst_ni : asynchronous active-low reset
//   nav    : ghost_nav_if.slave (enable, respawn, mode, target_x/y, blocked in;
//            x, y, direction, step, stuck out)
module ghost_nav_ctrl #(
   parameter int          X_W         = 10,
   parameter int          Y_W         = 9,
   parameter int          START_X     = 200,
   parameter int          START_Y     = 146,
   parameter int          X_MAX       = 639,
   parameter int          Y_MAX       = 479,
   parameter int          STEP_PERIOD = 131072,
   parameter int          SETTLE_CYC  = 2,
   parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
   input logic        clk_i,
   input logic        rst_ni,
   ghost_nav_if.slave nav
);
   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_MOVE   = 3'd1;
   localparam logic [2:0] S_TURN   = 3'd2;
   localparam logic [2:0] S_SETTLE = 3'd3;
   localparam logic [2:0] S_HOLD   = 3'd4;
   localparam int CW  = (STEP_PERIOD > 2) ? $clog2(STEP_PERIOD) : 1;
   localparam int SW  = $clog2(SETTLE_CYC + 1);
   localparam int D_W = ((X_W > Y_W) ? X_W : Y_W) + 1;

   logic [2:0]            state_q, state_d;
   logic [X_W-1:0]        x_q, x_d, nx;
   logic [Y_W-1:0]        y_q, y_d, ny;
   logic [1:0]            dir_q, dir_d, first_q, first_d, first_c, chase_dir;
   logic [2:0]            retry_q, retry_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [SW-1:0]         sc_q, sc_d;
   logic [15:0]           lfsr_q, lfsr_d;
   logic                  step_q, step_d, stuck_q, stuck_d, tick, can_move;
   logic signed [D_W-1:0] dx, dy;
   logic [D_W-1:0]        adx, ady;

   // Steering: chase picks the axis with the larger distance (ties to x); retries rotate
   // from the first candidate so all four headings are tried before giving up.
   always_comb begin
      dx        = D_W'(nav.target_x) - D_W'(x_q);
      dy        = D_W'(nav.target_y) - D_W'(y_q);
      adx       = dx[D_W-1] ? -dx : dx;
      ady       = dy[D_W-1] ? -dy : dy;
      chase_dir = (dx == 0 && dy == 0) ? dir_q :
                  (adx >= ady) ? (dx[D_W-1] ? 2'b10 : 2'b11) :
                  (dy[D_W-1] ? 2'b00 : 2'b01);
      first_c   = (retry_q == 3'd0) ? (nav.mode ? chase_dir : lfsr_q[1:0]) : first_q;
   end

   // Horizontal moves wrap through the tunnel; vertical edges are walls.
   always_comb begin
      can_move = (dir_q == 2'b00) ? (y_q != '0) :
                 (dir_q == 2'b01) ? (y_q != Y_W'(Y_MAX)) : 1'b1;
      nx       = (dir_q == 2'b10) ? ((x_q == '0) ? X_W'(X_MAX) : x_q - X_W'(1)) :
                 (dir_q == 2'b11) ? ((x_q == X_W'(X_MAX)) ? '0 : x_q + X_W'(1)) : x_q;
      ny       = (dir_q == 2'b00) ? y_q - Y_W'(1) :
                 (dir_q == 2'b01) ? y_q + Y_W'(1) : y_q;
   end

   always_comb begin
      lfsr_d  = (lfsr_q == '0) ? LFSR_SEED :
                {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      tick    = nav.enable && (cnt_q == CW'(STEP_PERIOD - 1));
      cnt_d   = tick ? '0 : nav.enable ? cnt_q + CW'(1) : cnt_q;
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      dir_d   = dir_q;
      step_d  = 1'b0;
      stuck_d = stuck_q;
      retry_d = retry_q;
      first_d = first_q;
      sc_d    = sc_q;
      case (state_q)
         S_IDLE: if (nav.enable) state_d = S_MOVE;
         S_MOVE: begin
            if (!nav.enable) state_d = S_IDLE;
            else if (tick && (nav.blocked || !can_move)) state_d = S_TURN;
            else if (tick) begin
               x_d     = nx;
               y_d     = ny;
               step_d  = 1'b1;
               retry_d = '0;
            end
         end
         S_TURN: begin
            if (retry_q == 3'd4) begin
               stuck_d = 1'b1;
               state_d = S_HOLD;
            end else begin
               first_d = first_c;
               dir_d   = first_c + retry_q[1:0];
               retry_d = retry_q + 3'd1;
               sc_d    = '0;
               state_d = S_SETTLE;
            end
         end
         S_SETTLE: begin
            if (sc_q == SW'(SETTLE_CYC - 1)) state_d = nav.blocked ? S_TURN : S_MOVE;
            else sc_d = sc_q + SW'(1);
         end
         S_HOLD: ;
         default: state_d = S_IDLE;
      endcase
      if (nav.respawn) begin
         state_d = S_IDLE;
         x_d     = X_W'(START_X);
         y_d     = Y_W'(START_Y);
         dir_d   = 2'b00;
         step_d  = 1'b0;
         stuck_d = 1'b0;
         retry_d = '0;
         sc_d    = '0;
         cnt_d   = '0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
         x_q     <= X_W'(START_X);
         y_q     <= Y_W'(START_Y);
         dir_q   <= 2'b00;
         step_q  <= 1'b0;
         stuck_q <= 1'b0;
         retry_q <= '0;
         first_q <= 2'b00;
         cnt_q   <= '0;
         sc_q    <= '0;
         lfsr_q  <= LFSR_SEED;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         dir_q   <= dir_d;
         step_q  <= step_d;
         stuck_q <= stuck_d;
         retry_q <= retry_d;
         first_q <= first_d;
         cnt_q   <= cnt_d;
         sc_q    <= sc_d;
         lfsr_q  <= lfsr_d;
      end
   end

   assign nav.x         = x_q;
   assign nav.y         = y_q;
   assign nav.direction = dir_q;
   assign nav.step      = step_q;
   assign nav.stuck     = stuck_q;
endmodule

// File: tb/tb_ghost_nav_ctrl.sv
// tb_ghost_nav_ctrl: directed and random checks of two ghost controllers against a behavioural model.
module tb_ghost_nav_ctrl;
   localparam int          P    = 4;
   localparam int          SC   = 2;
   localparam int          XM   = 639;
   localparam int          YM   = 479;
   localparam logic [15:0] SEED = 16'hACE1;
   localparam int PH_IDLE = 0, PH_MOVE = 1, PH_TURN = 2, PH_SETTLE = 3, PH_HOLD = 4;

   typedef struct {
      int x, y, dir, step, stuck, ph, cnt, retry, first, sc;
      logic [15:0] lfsr;
   } mdl_t;

   logic       clk = 0, rst_n = 0;
   logic       en, rsp, md, blk1, blk2;
   logic [9:0] tx;
   logic [8:0] ty;
   mdl_t       m1, m2;
   int         n_cmp = 0, n_bad = 0, hx, hy, hd;

   always #5 clk = ~clk;

   ghost_nav_if a ();
   ghost_nav_if b ();
   assign a.enable = en;  assign a.respawn = rsp; assign a.mode = md;
   assign a.target_x = tx; assign a.target_y = ty; assign a.blocked = blk1;
   assign b.enable = en;  assign b.respawn = rsp; assign b.mode = md;
   assign b.target_x = tx; assign b.target_y = ty; assign b.blocked = blk2;

   ghost_nav_ctrl #(.STEP_PERIOD(P), .SETTLE_CYC(SC)) u1 (.clk_i(clk), .rst_ni(rst_n), .nav(a.slave));
   ghost_nav_ctrl #(.STEP_PERIOD(P), .SETTLE_CYC(SC), .START_X(0)) u2 (.clk_i(clk), .rst_ni(rst_n), .nav(b.slave));

   function automatic mdl_t mreset(int sx);
      mdl_t r;
      r.x = sx; r.y = 146; r.dir = 0; r.step = 0; r.stuck = 0; r.ph = PH_IDLE;
      r.cnt = 0; r.retry = 0; r.first = 0; r.sc = 0; r.lfsr = SEED;
      return r;
   endfunction

   function automatic int heading(mdl_t m);
      int dx, dy;
      if (!md) return int'(m.lfsr[1:0]);
      dx = int'(tx) - m.x;
      dy = int'(ty) - m.y;
      if (dx == 0 && dy == 0) return m.dir;
      if ((dx < 0 ? -dx : dx) >= (dy < 0 ? -dy : dy)) return dx < 0 ? 2 : 3;
      return dy < 0 ? 0 : 1;
   endfunction

   function automatic mdl_t mnext(mdl_t m, logic blk, int sx);
      mdl_t n = m;
      int nx, ny;
      bit ok, tk;
      n.step = 0;
      n.lfsr = (m.lfsr == 0) ? SEED : {m.lfsr[14:0], m.lfsr[15] ^ m.lfsr[13] ^ m.lfsr[12] ^ m.lfsr[10]};
      tk = en && m.cnt == P - 1;
      if (en) n.cnt = (m.cnt + 1) % P;
      if (rsp) begin
         n.x = sx; n.y = 146; n.dir = 0; n.stuck = 0; n.ph = PH_IDLE;
         n.cnt = 0; n.retry = 0; n.sc = 0;
         return n;
      end
      case (m.ph)
         PH_IDLE: if (en) n.ph = PH_MOVE;
         PH_MOVE: begin
            if (!en) n.ph = PH_IDLE;
            else if (tk) begin
               nx = m.x; ny = m.y; ok = 1;
               case (m.dir)
                  0: begin ok = m.y > 0;  ny = m.y - 1; end
                  1: begin ok = m.y < YM; ny = m.y + 1; end
                  2: nx = (m.x + XM) % (XM + 1);
                  default: nx = (m.x + 1) % (XM + 1);
               endcase
               if (blk || !ok) n.ph = PH_TURN;
               else begin n.x = nx; n.y = ny; n.step = 1; n.retry = 0; end
            end
         end
         PH_TURN: begin
            if (m.retry == 4) begin n.stuck = 1; n.ph = PH_HOLD; end
            else begin
               if (m.retry == 0) n.first = heading(m);
               n.dir = (n.first + m.retry) % 4;
               n.retry = m.retry + 1;
               n.sc = 0;
               n.ph = PH_SETTLE;
            end
         end
         PH_SETTLE: if (m.sc == SC - 1) n.ph = blk ? PH_TURN : PH_MOVE; else n.sc = m.sc + 1;
         default: ;
      endcase
      return n;
   endfunction

   always @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         m1 <= mreset(200);
         m2 <= mreset(0);
      end else begin
         m1 <= mnext(m1, blk1, 200);
         m2 <= mnext(m2, blk2, 0);
      end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
      chk("x1", a.x, m1.x);     chk("y1", a.y, m1.y);     chk("dir1", a.direction, m1.dir);
      chk("step1", a.step, m1.step); chk("stuck1", a.stuck, m1.stuck);
      chk("x2", b.x, m2.x);     chk("y2", b.y, m2.y);     chk("dir2", b.direction, m2.dir);
      chk("step2", b.step, m2.step); chk("stuck2", b.stuck, m2.stuck);
   endtask

   initial begin
      en = 0; rsp = 0; md = 0; tx = 0; ty = 0; blk1 = 0; blk2 = 0;
      repeat (2) cyc();
      chk("rst_x", a.x, 200); chk("rst_y", a.y, 146); chk("rst_dir", a.direction, 0);
      chk("rst_step", a.step, 0); chk("rst_stuck", a.stuck, 0);
      rst_n = 1; en = 1;
      repeat (4) cyc();
      chk("walk_y145", a.y, 145); chk("walk_step", a.step, 1);
      cyc();
      chk("walk_step_low", a.step, 0);
      repeat (3) cyc();
      chk("walk_y144", a.y, 144); chk("walk_x", a.x, 200);
      md = 1; tx = 250; ty = 146; blk1 = 1;
      for (int i = 0; i < 20 && m1.ph != PH_SETTLE; i++) cyc();
      chk("chase_settle_to", m1.ph, PH_SETTLE);
      blk1 = 0;
      chk("chase_dir", a.direction, 3);
      for (int i = 0; i < 20 && !m1.step; i++) cyc();
      chk("chase_x", a.x, 201); chk("chase_y", a.y, 144);
      en = 0; hx = m1.x; hy = m1.y; hd = m1.dir;
      repeat (20) begin
         cyc();
         chk("hold_x", a.x, hx); chk("hold_y", a.y, hy);
         chk("hold_dir", a.direction, hd); chk("hold_step", a.step, 0);
      end
      en = 1;
      for (int i = 0; i < 40 && !m1.step; i++) cyc();
      chk("resume_step", a.step, 1); chk("resume_x", a.x, hx + 1);
      md = 0; blk1 = 1;
      for (int i = 0; i < 200 && !m1.stuck; i++) cyc();
      chk("stuck", a.stuck, 1);
      hx = m1.x; hy = m1.y;
      repeat (8) begin
         cyc();
         chk("frozen_x", a.x, hx); chk("frozen_y", a.y, hy);
      end
      rsp = 1;
      cyc();
      rsp = 0;
      chk("rsp_stuck", a.stuck, 0); chk("rsp_x", a.x, 200); chk("rsp_y", a.y, 146);
      chk("rsp_dir", a.direction, 0);
      blk1 = 0;
      repeat (10) cyc();
      blk1 = 1;
      for (int i = 0; i < 20 && m1.ph != PH_SETTLE; i++) cyc();
      chk("settle_to", m1.ph, PH_SETTLE);
      #2 rst_n = 0;
      #1;
      chk("arst_x", a.x, 200); chk("arst_y", a.y, 146); chk("arst_dir", a.direction, 0);
      chk("arst_step", a.step, 0); chk("arst_stuck", a.stuck, 0);
      cyc();
      rst_n = 1; blk1 = 0; md = 0;
      for (int i = 0; i < 300 && !(m2.step && m2.x == XM); i++) begin
         blk2 = (m2.dir != 2);
         cyc();
      end
      chk("tunnel_x", b.x, XM); chk("tunnel_y", b.y, 146); chk("tunnel_step", b.step, 1);
      for (int i = 0; i < 3000; i++) begin
         cyc();
         en   = ($urandom_range(0, 9) != 0);
         rsp  = ($urandom_range(0, 79) == 0);
         if ($urandom_range(0, 49) == 0) md = ~md;
         if ($urandom_range(0, 19) == 0) begin
            tx = 10'($urandom_range(0, XM));
            ty = 9'($urandom_range(0, YM));
         end
         blk1 = ($urandom_range(0, 3) == 0);
         blk2 = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 499) == 0) begin
            #2 rst_n = 0;
            #1 rst_n = 1;
         end
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
